fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that sits directly upstream of the PC register.
- Computes next_pc, which the PC register loads every clock, and reads the current PC back.
- Runs a req/ack handshake to instruction memory and presents each fetched instruction to decode over a valid/ready handshake.
- Handles branch redirects, including discarding a memory response that is already in flight.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch
//               sequencer: FSM state encoding, default widths and the PC
//               value used when the sequencer is cleared.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Default widths for the fetch path.
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    // PC value presented on next_pc while clear is asserted.
    localparam int unsigned RESET_PC = 0;

    // Fetch FSM state encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer sitting directly upstream of the
//               PC register. Drives next_pc every cycle, issues one
//               req/ack memory transaction at a time and hands each fetched
//               instruction to decode over a valid/ready handshake. Branch
//               redirects squash the held instruction or discard a memory
//               response that is already in flight.
// Ports       : clock, clear             - clock, synchronous active-high reset
//               pc_in / next_pc          - PC register read-back / load value
//               imem_req/addr/ack/rdata  - instruction memory handshake
//               redirect_valid/target    - taken branch or jump (1-cycle pulse)
//               instr_valid/instr/instr_pc/instr_ready - decode handshake
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_addr_q;
    logic               r_drop;        // in-flight response belongs to a squashed path
    logic [INSTR_W-1:0] r_instr_q;
    logic [ADDR_W-1:0]  r_instr_pc_q;
    logic               r_valid_q;

    fetch_state_e       w_state_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_drop_nxt;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [ADDR_W-1:0]  w_instr_pc_nxt;
    logic               w_valid_nxt;

    // A response is usable only if nothing has redirected the path since the
    // request was issued.
    logic               w_good_ack;
    assign w_good_ack = (r_state == S_REQ) && imem_ack && !r_drop;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state      <= S_IDLE;
            r_addr_q     <= '0;
            r_drop       <= 1'b0;
            r_instr_q    <= '0;
            r_instr_pc_q <= '0;
            r_valid_q    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr_q     <= w_addr_nxt;
            r_drop       <= w_drop_nxt;
            r_instr_q    <= w_instr_nxt;
            r_instr_pc_q <= w_instr_pc_nxt;
            r_valid_q    <= w_valid_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr_q;
        w_drop_nxt     = r_drop;
        w_instr_nxt    = r_instr_q;
        w_instr_pc_nxt = r_instr_pc_q;
        w_valid_nxt    = r_valid_q;

        case (r_state)
            S_IDLE: begin
                // On a redirect pc_in has not yet picked up the target, so
                // wait one cycle before latching the fetch address.
                if (!redirect_valid) begin
                    w_addr_nxt  = pc_in;
                    w_state_nxt = S_REQ;
                end
            end

            S_REQ: begin
                if (imem_ack) begin
                    if (r_drop || redirect_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_instr_nxt    = imem_rdata;
                        w_instr_pc_nxt = r_addr_q;
                        w_valid_nxt    = 1'b1;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // The request cannot be withdrawn; remember to discard
                    // its response when it finally arrives.
                    w_drop_nxt = 1'b1;
                end
            end

            S_HOLD: begin
                // A redirect wins over a same-cycle accept.
                if (redirect_valid || instr_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        imem_req    = (r_state == S_REQ);
        // Decoded from registered state only, so the address cannot move
        // while a request is outstanding.
        imem_addr   = (r_state == S_REQ) ? r_addr_q : '0;
        instr_valid = r_valid_q;
        instr       = r_instr_q;
        instr_pc    = r_instr_pc_q;

        if (clear) begin
            next_pc = ADDR_W'(RESET_PC);
        end else if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (w_good_ack) begin
            next_pc = r_addr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
        end else begin
            next_pc = pc_in;
        end
    end

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. Models the PC register
//               and an instruction memory with programmable latency; expected
//               request addresses and delivered instructions are queued by
//               the stimulus and compared as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    logic               clock = 1'b0;
    logic               clear;
    logic [ADDR_W-1:0]  pc_in = '0;
    logic [ADDR_W-1:0]  next_pc;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Memory model controls.
    int                 mem_lat    = 1;
    logic               mem_ovr_en = 1'b0;
    logic [INSTR_W-1:0] mem_ovr_data = '0;

    // Scoreboards.
    logic [ADDR_W-1:0]  exp_req[$];
    logic [ADDR_W-1:0]  exp_pc[$];
    logic [INSTR_W-1:0] exp_ins[$];
    int                 acc_cyc[$];

    logic               req_open = 1'b0;
    logic [ADDR_W-1:0]  req_addr = '0;

    fetch_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clock           (clock),
        .clear           (clear),
        .pc_in           (pc_in),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready)
    );

    always #5 clock = ~clock;

    // PC register next to the sequencer.
    always @(posedge clock) begin
        pc_in <= next_pc;
        cyc   <= cyc + 1;
    end

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Instruction memory: acks mem_lat cycles after the request is first seen.
    initial begin
        int cnt;
        cnt        = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            imem_ack = 1'b0;
            if (clear) begin
                cnt = 0;
            end else if (imem_req) begin
                if (cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_ovr_en ? mem_ovr_data : mem_word(imem_addr);
                    mem_ovr_en = 1'b0;
                    cnt        = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Request monitor: new request addresses against the queue, and address
    // stability while a request is outstanding.
    initial begin
        logic [ADDR_W-1:0] e;
        forever begin
            @(negedge clock);
            if (clear) begin
                req_open = 1'b0;
            end else begin
                if (imem_req && !req_open) begin
                    req_open = 1'b1;
                    req_addr = imem_addr;
                    if (exp_req.size() != 0) begin
                        e = exp_req.pop_front();
                        check_eq("req_addr", 32'(imem_addr), 32'(e));
                    end
                end else if (imem_req && req_open) begin
                    check_eq("req_addr_stable", 32'(imem_addr), 32'(req_addr));
                end
                if (imem_req && imem_ack) req_open = 1'b0;
            end
        end
    end

    // Instruction monitor: every accepted instruction must be the next one
    // queued; an accept in a redirect cycle does not count.
    initial begin
        logic [ADDR_W-1:0]  ep;
        logic [INSTR_W-1:0] ei;
        forever begin
            @(negedge clock);
            if (!clear && instr_valid && instr_ready && !redirect_valid) begin
                acc_cyc.push_back(cyc);
                check_eq("instr_expected", 32'(exp_pc.size() != 0), 32'd1);
                if (exp_pc.size() != 0) begin
                    ep = exp_pc.pop_front();
                    ei = exp_ins.pop_front();
                    check_eq("instr_pc", 32'(instr_pc), 32'(ep));
                    check_eq("instr", 32'(instr), 32'(ei));
                end
            end
        end
    end

    task automatic push_instr(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        exp_pc.push_back(a);
        exp_ins.push_back(d);
    endtask

    task automatic wait_instr_drain(input string tag);
        int n;
        n = 0;
        while (exp_pc.size() != 0 && n < 60) begin
            step();
            n++;
        end
        check_eq(tag, 32'(exp_pc.size()), 32'd0);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check_eq(tag, 32'(imem_req), 32'd1);
    endtask

    task automatic end_test(input string tag);
        instr_ready = 1'b0;
        step();
        step();
        check_eq(tag, 32'(exp_req.size() + exp_pc.size()), 32'd0);
    endtask

    initial begin
        int n;
        clear           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        instr_ready     = 1'b1;

        // ---------------- 1: reset and sequential fetch ----------------
        for (int i = 0; i < 3; i++) begin
            exp_req.push_back(ADDR_W'(i));
            push_instr(ADDR_W'(i), mem_word(ADDR_W'(i)));
        end
        step();
        check_eq("t1_next_pc_clear_a", 32'(next_pc), 32'd0);
        step();
        check_eq("t1_next_pc_clear_b", 32'(next_pc), 32'd0);
        check_eq("t1_rst_req", 32'(imem_req), 32'd0);
        check_eq("t1_rst_addr", 32'(imem_addr), 32'd0);
        check_eq("t1_rst_valid", 32'(instr_valid), 32'd0);
        check_eq("t1_rst_instr", 32'(instr), 32'd0);
        check_eq("t1_rst_instr_pc", 32'(instr_pc), 32'd0);
        acc_cyc.delete();
        clear = 1'b0;
        wait_instr_drain("t1_drain");
        instr_ready = 1'b0;
        check_eq("t1_accepts", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3) begin
            check_eq("t1_spacing_a", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
            check_eq("t1_spacing_b", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        end
        end_test("t1_sb_empty");

        // ---------------- 2: wrap-around ----------------
        clear = 1'b1;
        exp_req.push_back(8'hFF);
        exp_req.push_back(8'h00);
        push_instr(8'hFF, mem_word(8'hFF));
        push_instr(8'h00, mem_word(8'h00));
        step();
        clear           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 8'hFF;
        instr_ready     = 1'b1;
        step();
        redirect_valid  = 1'b0;
        n = 0;
        while (!(imem_req && imem_ack && imem_addr == 8'hFF) && n < 20) begin
            step();
            n++;
        end
        check_eq("t2_ack_ff_seen", 32'(n < 20), 32'd1);
        check_eq("t2_next_pc_wrap", 32'(next_pc), 32'h00);
        wait_instr_drain("t2_drain");
        end_test("t2_sb_empty");

        // ---------------- 3: back-pressure ----------------
        clear = 1'b1;
        exp_req.push_back(8'h00);
        exp_req.push_back(8'h01);
        push_instr(8'h00, mem_word(8'h00));
        step();
        clear = 1'b0;
        n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_valid", 32'(instr_valid), 32'd1);
            check_eq("t3_instr", 32'(instr), 32'(mem_word(8'h00)));
            check_eq("t3_instr_pc", 32'(instr_pc), 32'h00);
            check_eq("t3_req", 32'(imem_req), 32'd0);
            check_eq("t3_next_pc", 32'(next_pc), 32'h01);
            step();
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check_eq("t3_idle_req", 32'(imem_req), 32'd0);
        step();
        check_eq("t3_resume_req", 32'(imem_req), 32'd1);
        check_eq("t3_resume_addr", 32'(imem_addr), 32'h01);
        end_test("t3_sb_empty");

        // ---------------- 4: redirect with a request in flight ----------------
        clear        = 1'b1;
        mem_lat      = 3;
        mem_ovr_en   = 1'b1;
        mem_ovr_data = 16'hBEEF;
        exp_req.push_back(8'h05);
        exp_req.push_back(8'h40);
        push_instr(8'h40, mem_word(8'h40));
        instr_ready = 1'b1;
        step();
        clear           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 8'h05;
        step();
        redirect_valid  = 1'b0;
        wait_req("t4_req_05");
        redirect_valid  = 1'b1;
        redirect_target = 8'h40;
        step();
        redirect_valid  = 1'b0;
        n = 0;
        while (!imem_ack && n < 20) begin
            check_eq("t4_addr_hold", 32'(imem_addr), 32'h05);
            check_eq("t4_no_valid", 32'(instr_valid), 32'd0);
            step();
            n++;
        end
        check_eq("t4_ack_seen", 32'(imem_ack), 32'd1);
        check_eq("t4_ack_addr", 32'(imem_addr), 32'h05);
        mem_lat = 1;
        step();
        check_eq("t4_squashed", 32'(instr_valid), 32'd0);
        wait_instr_drain("t4_drain");
        end_test("t4_sb_empty");

        // ---------------- 5: redirect while holding, ready high ----------------
        clear = 1'b1;
        exp_req.push_back(8'h00);
        exp_req.push_back(8'h80);
        push_instr(8'h80, mem_word(8'h80));
        step();
        clear = 1'b0;
        n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("t5_hold_valid", 32'(instr_valid), 32'd1);
        redirect_valid  = 1'b1;
        redirect_target = 8'h80;
        instr_ready     = 1'b1;
        step();
        redirect_valid  = 1'b0;
        check_eq("t5_squash_valid", 32'(instr_valid), 32'd0);
        wait_req("t5_req_80");
        check_eq("t5_req_addr", 32'(imem_addr), 32'h80);
        wait_instr_drain("t5_drain");
        end_test("t5_sb_empty");

        // ---------------- 6: clear in the middle of a request ----------------
        clear   = 1'b1;
        mem_lat = 5;
        exp_req.push_back(8'h30);
        exp_req.push_back(8'h00);
        step();
        clear           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 8'h30;
        step();
        redirect_valid  = 1'b0;
        wait_req("t6_req_30");
        check_eq("t6_req_addr", 32'(imem_addr), 32'h30);
        step();
        clear = 1'b1;
        step();
        clear   = 1'b0;
        mem_lat = 1;
        check_eq("t6_req_off", 32'(imem_req), 32'd0);
        check_eq("t6_valid_off", 32'(instr_valid), 32'd0);
        check_eq("t6_next_pc", 32'(next_pc), 32'h00);
        step();
        check_eq("t6_restart_req", 32'(imem_req), 32'd1);
        check_eq("t6_restart_addr", 32'(imem_addr), 32'h00);
        end_test("t6_sb_empty");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
